// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB master sequencer and its arbiter.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_t;

    localparam int unsigned APB_ADDR_W = 8;
    localparam int unsigned APB_DATA_W = 32;

    // Index width for an n-entry selector; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after last_gnt, wrapping.
module rr_arbiter
    import apb_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_gnt,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          valid
);

    always_comb begin
        int unsigned j;
        gnt     = '0;
        gnt_idx = '0;
        valid   = 1'b0;
        j       = 0;
        for (int unsigned off = 1; off <= N; off++) begin
            j = 32'(last_gnt) + off;
            if (j >= N) begin
                j = j - N;
            end
            if (!valid && req[j]) begin
                valid   = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/apb_master_arb.sv
// APB master sequencer sharing one slave between NUM_REQ requesters, round-robin arbitrated.
module apb_master_arb
    import apb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = APB_ADDR_W,
    parameter int unsigned DATA_W  = APB_DATA_W,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          done,
    output logic                        err,
    output logic [DATA_W-1:0]           rdata,
    output logic                        busy,
    output logic                        psel,
    output logic                        penable,
    output logic                        pwrite,
    output logic [ADDR_W-1:0]           paddr,
    output logic [DATA_W-1:0]           pwdata,
    input  logic [DATA_W-1:0]           prdata,
    input  logic                        pready
);

    localparam int unsigned   IW        = idx_w(NUM_REQ);
    localparam int unsigned   CW        = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0] GNT_RESET = IW'(NUM_REQ - 1);

    apb_state_t state_q, state_d;
    logic [IW-1:0] last_gnt_q, last_gnt_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic               arb_valid;

    logic [NUM_REQ-1:0] done_d;
    logic               err_d, busy_d, psel_d, penable_d, pwrite_d;
    logic [DATA_W-1:0]  rdata_d, pwdata_d;
    logic [ADDR_W-1:0]  paddr_d;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .req      (req),
        .last_gnt (last_gnt_q),
        .gnt      (arb_gnt),
        .gnt_idx  (arb_idx),
        .valid    (arb_valid)
    );

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        cnt_d      = cnt_q;
        done_d     = '0;
        err_d      = 1'b0;
        rdata_d    = rdata;
        busy_d     = busy;
        psel_d     = psel;
        penable_d  = penable;
        pwrite_d   = pwrite;
        paddr_d    = paddr;
        pwdata_d   = pwdata;

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    last_gnt_d = arb_idx;
                    for (int unsigned k = 0; k < NUM_REQ; k++) begin
                        if (arb_gnt[k]) begin
                            pwrite_d = req_write[k];
                            paddr_d  = req_addr[k*ADDR_W +: ADDR_W];
                            pwdata_d = req_wdata[k*DATA_W +: DATA_W];
                        end
                    end
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // last_gnt_q still names the owner of the transfer in flight
                if (pready || (cnt_q == CNT_LAST)) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    busy_d    = 1'b0;
                    err_d     = !pready;
                    for (int unsigned k = 0; k < NUM_REQ; k++) begin
                        done_d[k] = (last_gnt_q == IW'(k));
                    end
                    if (pready && !pwrite) begin
                        rdata_d = prdata;
                    end
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            last_gnt_q <= GNT_RESET;
            cnt_q      <= '0;
            done       <= '0;
            err        <= 1'b0;
            rdata      <= '0;
            busy       <= 1'b0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= '0;
            pwdata     <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            cnt_q      <= cnt_d;
            done       <= done_d;
            err        <= err_d;
            rdata      <= rdata_d;
            busy       <= busy_d;
            psel       <= psel_d;
            penable    <= penable_d;
            pwrite     <= pwrite_d;
            paddr      <= paddr_d;
            pwdata     <= pwdata_d;
        end
    end

endmodule

// File: tb/tb_apb_master_arb.sv
// Self-checking bench: transaction-level requester/slave model against apb_master_arb.
module tb_apb_master_arb;

    localparam int N  = 3;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req, req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    done;
    logic            err, busy, psel, penable, pwrite, pready;
    logic [DW-1:0]   rdata, pwdata, prdata;
    logic [AW-1:0]   paddr;

    apb_master_arb #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .busy      (busy),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // requester-side pending commands
    logic [N-1:0]  pv, pw;
    logic [AW-1:0] pa [N];
    logic [DW-1:0] pd [N];
    int            pwt [N];

    // reference state
    logic [DW-1:0] mmem [256];
    logic [DW-1:0] smem [256];
    logic [DW-1:0] exp_rdata, cd;
    logic [AW-1:0] ca;
    logic          cw, exp_err, inflight, start_exp;
    int            ptr, cur, t, acc_len, cwt, cyc, last_done_cyc, refill_cnt;
    int            grants [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int off = 1; off <= N; off++) begin
            int j;
            j = (p + off) % N;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            bit live;
            live = pv[i] && !(inflight && i == cur);
            if (inflight) req[i] = (pv[i] && i != cur) ? 1'b1 : 1'($urandom);
            else          req[i] = pv[i];
            req_write[i]           = live ? pw[i] : 1'($urandom);
            req_addr[i*AW +: AW]   = live ? pa[i] : AW'($urandom);
            req_wdata[i*DW +: DW]  = live ? pd[i] : $urandom;
        end
        start_exp = !inflight && (|pv);
    endtask

    task automatic new_cmd(input int i, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input int waits);
        pv[i] = 1'b1; pw[i] = w; pa[i] = a; pd[i] = d; pwt[i] = waits;
        drive_reqs();
    endtask

    task automatic rand_cmd(input int i);
        int r, waits;
        r = $urandom_range(0, 9);
        if (r <= 5)      waits = 0;
        else if (r <= 7) waits = $urandom_range(1, 3);
        else if (r == 8) waits = $urandom_range(TO - 2, TO - 1);
        else             waits = $urandom_range(TO, TO + 1);
        new_cmd(i, 1'($urandom), AW'($urandom), $urandom, waits);
    endtask

    // One clock: observe at the falling edge, compare with the model, drive the next inputs.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (!inflight) begin
            check("idle_psel", psel, start_exp);
            check("idle_penable", penable, 0);
            check("idle_busy", busy, start_exp);
            check("idle_done", done, 0);
            if (psel && start_exp) begin
                cur = pick(req, ptr);
                ptr = cur;
                grants.push_back(cur);
                check("setup_paddr", paddr, pa[cur]);
                check("setup_pwrite", pwrite, pw[cur]);
                if (pw[cur]) check("setup_pwdata", pwdata, pd[cur]);
                ca = pa[cur]; cw = pw[cur]; cd = pd[cur]; cwt = pwt[cur];
                acc_len  = (cwt < TO) ? cwt + 1 : TO;
                exp_err  = (cwt >= TO);
                inflight = 1'b1;
                t        = 0;
            end
        end else begin
            t++;
            if (t <= acc_len) begin
                check("acc_psel", psel, 1);
                check("acc_penable", penable, 1);
                check("acc_busy", busy, 1);
                check("acc_done", done, 0);
                check("acc_paddr", paddr, ca);
                check("acc_pwrite", pwrite, cw);
                if (cw) check("acc_pwdata", pwdata, cd);
            end else begin
                check("end_psel", psel, 0);
                check("end_penable", penable, 0);
                check("end_busy", busy, 0);
                check("done", done, 64'(1) << cur);
                check("err", err, exp_err);
                if (!exp_err && !cw) exp_rdata = mmem[ca];
                if (!exp_err && cw)  mmem[ca] = cd;
                check("rdata", rdata, exp_rdata);
                last_done_cyc = cyc;
                pv[cur]  = 1'b0;
                inflight = 1'b0;
                if (refill_cnt > 0) begin
                    refill_cnt--;
                    rand_cmd(cur);
                end
            end
        end
        // slave behaviour for the upcoming edge
        if (inflight && t >= 1 && t <= acc_len) begin
            pready = ((t - 1) >= cwt);
            if (pready && psel && penable && pwrite) smem[paddr] = pwdata;
            prdata = (pready && !pwrite) ? smem[paddr] : $urandom;
        end else begin
            pready = 1'($urandom);
            prdata = $urandom;
        end
        drive_reqs();
    endtask

    task automatic run_until_idle(input int budget);
        int k;
        k = 0;
        while ((inflight || (|pv)) && k < budget) begin
            step();
            k++;
        end
        check("idle_within_budget", inflight || (|pv), 0);
    endtask

    task automatic apply_reset(input int hold);
        #1 rst = 1'b1;
        #1;
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        pv = '0; inflight = 1'b0; ptr = N - 1; refill_cnt = 0; exp_rdata = '0;
        drive_reqs();
        repeat (hold) begin
            @(negedge clk);
            check("rst_hold_done", done, 0);
        end
        check("rst_err", err, 0);
        check("rst_rdata", rdata, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pwdata", pwdata, 0);
        check("rst_pwrite", pwrite, 0);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        logic [DW-1:0] saved;
        for (int i = 0; i < 256; i++) begin
            mmem[i] = {4{8'(i)}} ^ 32'h5A5A_0000;
            smem[i] = mmem[i];
        end
        pv = '0; pw = '0; inflight = 1'b0; cur = 0; t = 0; cyc = 0;
        last_done_cyc = 0; refill_cnt = 0; pready = 1'b0; prdata = '0;
        drive_reqs();
        apply_reset(2);

        // single write, zero wait
        new_cmd(0, 1'b1, 8'h05, 32'hA5A5_0001, 0);
        c0 = cyc;
        run_until_idle(50);
        check("t1_latency", last_done_cyc - c0, 3);

        // readback
        new_cmd(0, 1'b0, 8'h05, 32'h0, 0);
        run_until_idle(50);
        check("t2_rdata", rdata, 32'hA5A5_0001);

        // 64-entry write/read sweep
        for (int a = 0; a < 64; a++) begin
            new_cmd(a % N, 1'b1, AW'(a), $urandom, 0);
            run_until_idle(50);
        end
        for (int a = 0; a < 64; a++) begin
            new_cmd(a % N, 1'b0, AW'(a), $urandom, $urandom_range(0, 2));
            run_until_idle(50);
        end

        // contention right after reset: 0 first, then alternating
        apply_reset(2);
        grants.delete();
        new_cmd(0, 1'b1, 8'h10, 32'h1111_0000, 0);
        new_cmd(1, 1'b1, 8'h11, 32'h2222_0000, 0);
        refill_cnt = 6;
        run_until_idle(100);
        check("t3_grant_count", grants.size(), 8);
        for (int k = 0; k < 8 && k < grants.size(); k++) begin
            check("t3_alternate", grants[k], k % 2);
        end

        // three wait states
        new_cmd(0, 1'b1, 8'h20, 32'hCAFE_0004, 3);
        c0 = cyc;
        run_until_idle(50);
        check("t4_latency", last_done_cyc - c0, 6);

        // wait boundary: TO-1 waits still completes, TO waits times out
        new_cmd(2, 1'b1, 8'h21, 32'hBEEF_0015, TO - 1);
        c0 = cyc;
        run_until_idle(50);
        check("t5_edge_latency", last_done_cyc - c0, TO + 2);
        new_cmd(0, 1'b0, 8'h05, 32'h0, 0);
        run_until_idle(50);
        saved = mmem[8'h05];
        new_cmd(1, 1'b0, 8'h21, 32'h0, 1000);
        c0 = cyc;
        run_until_idle(50);
        check("t5_timeout_latency", last_done_cyc - c0, TO + 2);
        check("t5_rdata_hold", rdata, saved);

        // reset in the middle of ACCESS
        new_cmd(0, 1'b1, 8'h30, 32'h0BAD_0006, 5);
        for (int k = 0; k < 20 && !(inflight && t >= 2); k++) step();
        check("t6_reached_access", inflight && t >= 2, 1);
        apply_reset(2);
        grants.delete();
        new_cmd(1, 1'b1, 8'h31, 32'h600D_0006, 0);
        c0 = cyc;
        run_until_idle(50);
        check("t6_latency", last_done_cyc - c0, 3);
        check("t6_grant", grants.size() > 0 ? grants[0] : -1, 1);

        // randomized traffic
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                int i;
                i = $urandom_range(0, N - 1);
                if (!pv[i]) rand_cmd(i);
            end
            step();
        end
        run_until_idle(600);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
